// File: rtl/spi_to_nitta_assembler_pkg.sv
// Shared SPI/NITTA sizing helpers: subframes per word and subframe counter width.
// Used by both the SPI-to-NITTA assembler and the NITTA-to-SPI splitter.
package spi_to_nitta_assembler_pkg;

   function automatic int subframes_per_word(input int data_width, input int spi_data_width);
      return data_width / spi_data_width;
   endfunction

   function automatic int subframe_cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/spi_to_nitta_assembler_strobe.sv
// One acceptance per spi_ready high period; accept is combinational from armed & spi_ready.
// No backpressure: a level held high for any length yields a single accept.
module spi_ready_strobe (
   input  logic clk,
   input  logic rst,
   input  logic spi_ready,
   output logic accept
);

   logic armed;

   assign accept = armed & spi_ready;

   // A subframe already present when reset is applied must never be taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         armed <= ~spi_ready;
      end else if (!spi_ready) begin
         armed <= 1'b1;
      end else if (armed) begin
         armed <= 1'b0;
      end
   end

endmodule

// File: rtl/spi_to_nitta_assembler.sv
// Packs SPI subframes MSB-first into DATA_WIDTH words; word appears 1 cycle after last acceptance.
// No backpressure: an unread word is overwritten and flagged by sticky overrun.
module spi_to_nitta_assembler
   import spi_to_nitta_assembler_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int ATTR_WIDTH     = 4,
   parameter int SPI_DATA_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      spi_ready,
   input  logic [SPI_DATA_WIDTH-1:0] from_spi,
   input  logic                      spi_frame,
   output logic [DATA_WIDTH-1:0]     to_nitta,
   output logic                      word_valid,
   input  logic                      nitta_read,
   output logic                      overrun,
   output logic                      frame_error
);

   localparam int N  = subframes_per_word(DATA_WIDTH, SPI_DATA_WIDTH);
   localparam int CW = subframe_cnt_width(N);
   localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

   generate
      if ((DATA_WIDTH % SPI_DATA_WIDTH) != 0 || ATTR_WIDTH < 1) begin : g_bad_cfg
         $error("spi_to_nitta_assembler: DATA_WIDTH must be a multiple of SPI_DATA_WIDTH");
      end
   endgenerate

   logic                  accept;
   logic [CW-1:0]         cnt;
   logic [DATA_WIDTH-1:0] acc;
   logic [DATA_WIDTH-1:0] acc_next;
   logic                  word_done;

   spi_ready_strobe u_strobe (
      .clk       (clk),
      .rst       (rst),
      .spi_ready (spi_ready),
      .accept    (accept)
   );

   assign acc_next  = (acc << SPI_DATA_WIDTH) | DATA_WIDTH'(from_spi);
   assign word_done = spi_frame && accept && (cnt == LAST_CNT);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt         <= '0;
         acc         <= '0;
         to_nitta    <= '0;
         word_valid  <= 1'b0;
         overrun     <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         frame_error <= 1'b0;

         // Chip select dropped: drop any partial word and any subframe arriving now.
         if (!spi_frame) begin
            cnt         <= '0;
            acc         <= '0;
            frame_error <= (cnt != '0) || accept;
         end else if (accept) begin
            if (cnt == LAST_CNT) begin
               cnt <= '0;
               acc <= '0;
            end else begin
               cnt <= cnt + CW'(1);
               acc <= acc_next;
            end
         end

         // A completing word wins over a same-cycle read and is not an overrun.
         if (word_done) begin
            to_nitta   <= acc_next;
            word_valid <= 1'b1;
            if (word_valid && !nitta_read) begin
               overrun <= 1'b1;
            end
         end else if (nitta_read) begin
            word_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_spi_to_nitta_assembler.sv
// Directed bench: per-cycle vector table plus hand-written overrun/reset sequences.
module tb_spi_to_nitta_assembler;

   logic        clk = 1'b0;
   logic        rst;
   logic        spi_ready;
   logic [7:0]  from_spi;
   logic        spi_frame;
   logic [31:0] to_nitta;
   logic        word_valid;
   logic        nitta_read;
   logic        overrun;
   logic        frame_error;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic        rst;
      logic        rdy;
      logic [7:0]  dat;
      logic        frm;
      logic        rd;
      logic [31:0] etn;
      logic        ewv;
      logic        eov;
      logic        efe;
   } vec_t;

   vec_t vecs[$];

   spi_to_nitta_assembler #(
      .DATA_WIDTH     (32),
      .ATTR_WIDTH     (4),
      .SPI_DATA_WIDTH (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .spi_ready   (spi_ready),
      .from_spi    (from_spi),
      .spi_frame   (spi_frame),
      .to_nitta    (to_nitta),
      .word_valid  (word_valid),
      .nitta_read  (nitta_read),
      .overrun     (overrun),
      .frame_error (frame_error)
   );

   always #5 clk = ~clk;

   task automatic add(input logic r, input logic rdy, input logic [7:0] dat, input logic frm,
                      input logic rd, input logic [31:0] etn, input logic ewv,
                      input logic eov, input logic efe);
      vec_t v;
      v.rst = r; v.rdy = rdy; v.dat = dat; v.frm = frm; v.rd = rd;
      v.etn = etn; v.ewv = ewv; v.eov = eov; v.efe = efe;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (step %0d): got %h, expected %h", name, idx, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      spi_ready = 1'b1;
      from_spi  = b;
      tick();
      spi_ready = 1'b0;
      tick();
   endtask

   task automatic do_reset();
      rst = 1'b1; spi_ready = 1'b0; nitta_read = 1'b0; spi_frame = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; spi_ready = 1'b0; from_spi = 8'h00; spi_frame = 1'b1; nitta_read = 1'b0;

      // reset state
      add(1, 0, 8'h00, 1, 0, 32'h0, 0, 0, 0);
      add(1, 0, 8'h00, 1, 0, 32'h0, 0, 0, 0);
      // DE AD BE EF, each held high three cycles
      for (int k = 0; k < 3; k++) add(0, 1, 8'hDE, 1, 0, 32'h0, 0, 0, 0);
      add(0, 0, 8'h00, 1, 0, 32'h0, 0, 0, 0);
      for (int k = 0; k < 3; k++) add(0, 1, 8'hAD, 1, 0, 32'h0, 0, 0, 0);
      add(0, 0, 8'h00, 1, 0, 32'h0, 0, 0, 0);
      for (int k = 0; k < 3; k++) add(0, 1, 8'hBE, 1, 0, 32'h0, 0, 0, 0);
      add(0, 0, 8'h00, 1, 0, 32'h0, 0, 0, 0);
      for (int k = 0; k < 3; k++) add(0, 1, 8'hEF, 1, 0, 32'hDEADBEEF, 1, 0, 0);
      add(0, 0, 8'h00, 1, 1, 32'hDEADBEEF, 0, 0, 0);
      // long ready level yields one acceptance
      for (int k = 0; k < 10; k++) add(0, 1, 8'h55, 1, 0, 32'hDEADBEEF, 0, 0, 0);
      add(0, 0, 8'h00, 1, 0, 32'hDEADBEEF, 0, 0, 0);
      add(0, 1, 8'h66, 1, 0, 32'hDEADBEEF, 0, 0, 0);
      add(0, 0, 8'h00, 1, 0, 32'hDEADBEEF, 0, 0, 0);
      add(0, 1, 8'h77, 1, 0, 32'hDEADBEEF, 0, 0, 0);
      add(0, 0, 8'h00, 1, 0, 32'hDEADBEEF, 0, 0, 0);
      add(0, 1, 8'h88, 1, 0, 32'h55667788, 1, 0, 0);
      add(0, 0, 8'h00, 1, 1, 32'h55667788, 0, 0, 0);
      // frame drop mid-word
      add(0, 1, 8'h11, 1, 0, 32'h55667788, 0, 0, 0);
      add(0, 0, 8'h00, 1, 0, 32'h55667788, 0, 0, 0);
      add(0, 1, 8'h22, 1, 0, 32'h55667788, 0, 0, 0);
      add(0, 0, 8'h00, 1, 0, 32'h55667788, 0, 0, 0);
      add(0, 0, 8'h00, 0, 0, 32'h55667788, 0, 0, 1);
      add(0, 1, 8'h01, 1, 0, 32'h55667788, 0, 0, 0);
      add(0, 0, 8'h00, 1, 0, 32'h55667788, 0, 0, 0);
      add(0, 1, 8'h02, 1, 0, 32'h55667788, 0, 0, 0);
      add(0, 0, 8'h00, 1, 0, 32'h55667788, 0, 0, 0);
      add(0, 1, 8'h03, 1, 0, 32'h55667788, 0, 0, 0);
      add(0, 0, 8'h00, 1, 0, 32'h55667788, 0, 0, 0);
      add(0, 1, 8'h04, 1, 0, 32'h01020304, 1, 0, 0);
      add(0, 0, 8'h00, 1, 1, 32'h01020304, 0, 0, 0);
      // acceptance while frame is low is discarded and still consumes the ready level
      add(0, 1, 8'h99, 0, 0, 32'h01020304, 0, 0, 1);
      add(0, 1, 8'h99, 1, 0, 32'h01020304, 0, 0, 0);
      add(0, 0, 8'h00, 1, 0, 32'h01020304, 0, 0, 0);
      // idle frame drop with empty counter: no error
      add(0, 0, 8'h00, 0, 0, 32'h01020304, 0, 0, 0);
      add(0, 1, 8'h0A, 1, 0, 32'h01020304, 0, 0, 0);
      add(0, 0, 8'h00, 1, 0, 32'h01020304, 0, 0, 0);
      add(0, 1, 8'h0B, 1, 0, 32'h01020304, 0, 0, 0);
      add(0, 0, 8'h00, 1, 0, 32'h01020304, 0, 0, 0);
      add(0, 1, 8'h0C, 1, 0, 32'h01020304, 0, 0, 0);
      add(0, 0, 8'h00, 1, 0, 32'h01020304, 0, 0, 0);
      add(0, 1, 8'h0D, 1, 0, 32'h0A0B0C0D, 1, 0, 0);
      add(0, 0, 8'h00, 1, 1, 32'h0A0B0C0D, 0, 0, 0);
      // read with nothing pending
      add(0, 0, 8'h00, 1, 1, 32'h0A0B0C0D, 0, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         rst        = vecs[i].rst;
         spi_ready  = vecs[i].rdy;
         from_spi   = vecs[i].dat;
         spi_frame  = vecs[i].frm;
         nitta_read = vecs[i].rd;
         tick();
         check("vec to_nitta",    i, to_nitta,           vecs[i].etn);
         check("vec word_valid",  i, {31'b0, word_valid},  {31'b0, vecs[i].ewv});
         check("vec overrun",     i, {31'b0, overrun},     {31'b0, vecs[i].eov});
         check("vec frame_error", i, {31'b0, frame_error}, {31'b0, vecs[i].efe});
      end
      nitta_read = 1'b0;
      spi_frame  = 1'b1;

      // two unread words: overrun, second word kept
      do_reset();
      send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3); send_byte(8'hA4);
      check("ovr first valid", 0, {31'b0, word_valid}, 32'd1);
      check("ovr first clean", 0, {31'b0, overrun}, 32'd0);
      send_byte(8'hB1); send_byte(8'hB2); send_byte(8'hB3); send_byte(8'hB4);
      check("ovr flag", 0, {31'b0, overrun}, 32'd1);
      check("ovr word", 0, to_nitta, 32'hB1B2B3B4);
      nitta_read = 1'b1; tick(); nitta_read = 1'b0;
      check("ovr sticky", 0, {31'b0, overrun}, 32'd1);

      // read coinciding with completion: no overrun, still valid
      do_reset();
      send_byte(8'hC1); send_byte(8'hC2); send_byte(8'hC3); send_byte(8'hC4);
      send_byte(8'hD1); send_byte(8'hD2); send_byte(8'hD3);
      spi_ready = 1'b1; from_spi = 8'hD4; nitta_read = 1'b1;
      tick();
      nitta_read = 1'b0; spi_ready = 1'b0;
      check("coin valid", 0, {31'b0, word_valid}, 32'd1);
      check("coin overrun", 0, {31'b0, overrun}, 32'd0);
      check("coin word", 0, to_nitta, 32'hD1D2D3D4);
      tick();

      // reset with a subframe held on the bus
      rst = 1'b1; spi_ready = 1'b1; from_spi = 8'hAA;
      tick(); tick();
      check("rst to_nitta", 0, to_nitta, 32'h0);
      check("rst word_valid", 0, {31'b0, word_valid}, 32'd0);
      check("rst overrun", 0, {31'b0, overrun}, 32'd0);
      rst = 1'b0;
      tick(); tick(); tick();
      spi_ready = 1'b0; tick();
      check("rst held valid", 0, {31'b0, word_valid}, 32'd0);
      send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD); send_byte(8'hEE);
      check("rst held word", 0, to_nitta, 32'hBBCCDDEE);

      // reset mid-word discards partial word quietly
      nitta_read = 1'b1; tick(); nitta_read = 1'b0;
      send_byte(8'h12); send_byte(8'h34);
      rst = 1'b1; tick();
      check("midrst fe0", 0, {31'b0, frame_error}, 32'd0);
      rst = 1'b0; tick();
      check("midrst fe1", 0, {31'b0, frame_error}, 32'd0);
      send_byte(8'h56); send_byte(8'h78); send_byte(8'h9A); send_byte(8'hBC);
      check("midrst word", 0, to_nitta, 32'h56789ABC);
      check("midrst valid", 0, {31'b0, word_valid}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_to_nitta_assembler.md
SPI_TO_NITTA_ASSEMBLER -- requirements
Module: spi_to_nitta_assembler

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DATA_WIDTH, 32, assembled word width
- ATTR_WIDTH, 4, attribute width, reserved and unused
- SPI_DATA_WIDTH, 8, SPI subframe width
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock
- rst, in, 1, synchronous active-high reset
- spi_ready, in, 1, level; high while a freshly received subframe is on from_spi
- from_spi, in, SPI_DATA_WIDTH, received subframe
- spi_frame, in, 1, high while the SPI transaction (chip select) is active
- to_nitta, out, DATA_WIDTH, last complete word
- word_valid, out, 1, level; to_nitta holds an unread word
- nitta_read, in, 1, one-cycle pulse; consumer took to_nitta
- overrun, out, 1, sticky; an unread word was overwritten
- frame_error, out, 1, one-cycle pulse; frame ended mid-word
REQ-003 The design SHALL have one clock domain (clk) and a synchronous active-high reset (rst).

Function
REQ-004 Derived constants SHALL be N = DATA_WIDTH/SPI_DATA_WIDTH and counter width max(1, clog2(N)); DATA_WIDTH SHALL be an integer multiple of SPI_DATA_WIDTH.
REQ-005 Arming: an internal flag `armed` SHALL be set on any cycle with spi_ready=0; a subframe is accepted on a cycle with armed=1 and spi_ready=1, and that acceptance SHALL clear armed.
- One spi_ready high period SHALL yield exactly one acceptance, whatever its length.
REQ-006 Subframes SHALL be assembled MSB-first: the first accepted subframe becomes bits [DATA_WIDTH-1 : DATA_WIDTH-SPI_DATA_WIDTH]; the accumulator shifts left by SPI_DATA_WIDTH per acceptance.
REQ-007 On the acceptance that makes count = N:
- to_nitta SHALL update on the next clock edge (latency 1 cycle from acceptance).
- word_valid SHALL be 1 in that same cycle.
- The subframe counter SHALL wrap to 0.
REQ-008 With N=1, every acceptance SHALL produce a word.
REQ-009 to_nitta SHALL hold its value until the next completed word.
REQ-010 word_valid SHALL clear on the edge after nitta_read=1, unless a word completes in the same cycle; in that case word_valid stays 1 and overrun is unchanged.
REQ-011 A word completing while word_valid=1 and nitta_read=0 SHALL overwrite to_nitta and set overrun; overrun SHALL clear only on rst.
REQ-012 nitta_read while word_valid=0 SHALL have no effect.
REQ-013 Any cycle with spi_frame=0 SHALL force the counter and accumulator to 0; an acceptance in that cycle SHALL be discarded.
REQ-014 frame_error SHALL pulse for 1 cycle on the cycle after a spi_frame=0 cycle in which the counter was nonzero or an acceptance was discarded.
REQ-015 The armed logic SHALL be independent of spi_frame.

Reset
REQ-016 During rst, these SHALL go to 0 on the next edge: to_nitta, word_valid, overrun, frame_error, counter, accumulator.
REQ-017 During rst, armed SHALL become 0 if spi_ready=1 and 1 otherwise, so a subframe held across reset is never accepted.
REQ-018 A reset mid-word SHALL discard the partial word without a frame_error pulse.

Structure
REQ-019 N and the counter-width formula SHALL live in a shared SPI/NITTA parameter header; that header SHALL be used by this block and by the NITTA-to-SPI splitter.
REQ-020 Arming/edge detection SHALL be one sub-module, spi_ready_strobe (inputs clk, rst, spi_ready; output accept); all other logic SHALL be in spi_to_nitta_assembler.

Verification (defaults 32/8, spi_frame=1 unless stated)
REQ-021 Subframes DE, AD, BE, EF, each spi_ready high 3 cycles -> to_nitta=0xDEADBEEF, word_valid=1 one cycle after the 4th acceptance, no earlier change.
REQ-022 spi_ready held high 10 cycles with from_spi=0x55, then 3 more pulses 0x66/0x77/0x88 -> exactly one word, 0x55667788.
REQ-023 Bytes 11, 22, then spi_frame=0 for 1 cycle, then 01 02 03 04 -> frame_error pulse once; word = 0x01020304.
REQ-024 Two full words with no nitta_read -> overrun=1 and to_nitta = second word; nitta_read on the 2nd word's completion cycle instead -> overrun=0, word_valid=1.
REQ-025 rst asserted with spi_ready=1 and from_spi=0xAA, then released with spi_ready still high -> 0xAA not accepted; all outputs 0.
